sata_link_scrambler_mw: RTL and testbench
=========================================

Name: sata_link_scrambler_mw

Overview:
- Parametrised SATA link-layer scrambler/descrambler. Processes NDW dwords per beat over a valid/ready stream.
- XORs FIS payload dwords with the SATA scrambler keystream: G(X)=X16+X15+X13+X4+1, seed 0xF0F6, 32 keystream bits per dword.
- Primitive dwords bypass the XOR and do not consume keystream. The LFSR re-seeds at frame start.
- The same block serves as TX scrambler and RX descrambler, because XOR is symmetric.

Parameters:
- NDW, 1, dwords per beat; legal values 1, 2, 4.
- SEED, 16'hF0F6, LFSR value loaded on reset, init and SOF.
- POLY, 16'hA011, feedback taps for X15, X13, X4, 1; the X16 term is implicit. The per-dword 16x32 matrix is derived from POLY at elaboration.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- scr_en  in  1  1 = scramble data dwords; 0 = pass-through with the LFSR frozen. Sampled per accepted beat.
- lfsr_init  in  1  one-cycle pulse; LFSR <= SEED at the next edge.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  32*NDW  lane i = bits [32i+:32]; lane 0 is the earliest dword.
- in_prim  in  NDW  per-lane flag, 1 = primitive (bypassed).
- in_sof  in  1  beat holds the first dword of a frame.
- in_eof  in  1  beat holds the last dword of a frame.
- out_valid  out  1
- out_ready  in  1
- out_data  out  32*NDW
- out_prim  out  NDW
- out_sof  out  1
- out_eof  out  1

Behaviour:
- Keystream: k(0) = M·SEED, with the SATA byte order applied; k(0) must equal 32'hC2D2768D and k(1) must equal 32'h1F26B368. Each data dword consumes one k(n) and advances the 16-bit state by 32 shifts.
- Lane j gets its keystream from the count of non-primitive lanes below j, c_j = popcount(~in_prim[j-1:0]):
  - data lane j: out = in ^ k(n + c_j);
  - primitive lane: out = in unchanged.
  - After the beat, state advances by popcount(~in_prim) dwords (0..NDW).
  - Implemented as a combinational chain of NDW matrix stages with a mux on the count; no multicycle paths.
- SOF: on an accepted beat with in_sof=1, state is treated as SEED before lane 0 is processed (lane 0 data uses k(0)).
- EOF: no LFSR effect. The next frame re-seeds via SOF.
- scr_en=0: all lanes pass unchanged and the state holds. SOF with scr_en=0 still re-seeds.
- Priority at a clock edge (highest first):
  1. rst;
  2. lfsr_init;
  3. accepted beat (SOF seeding, then advance);
  4. hold.
  - lfsr_init and an accepted beat in the same cycle: the beat is processed from the current state, then the state is overwritten with SEED.
- Handshake:
  - one registered output stage; latency 1 cycle from acceptance to out_valid;
  - in_ready = ~out_valid | out_ready, full throughput;
  - outputs stay stable while out_valid & ~out_ready;
  - the LFSR advances only on acceptance.
- Reset values: out_valid=0, out_data=0, out_prim=0, out_sof=0, out_eof=0, LFSR=SEED. in_ready=1 during the cycle after reset.
- Reset mid-frame: any in-flight output beat is dropped; the next beat uses k(0) even if in_sof=0.
- Wrap: the state sequence period is 65535 dwords; there is no special handling at wrap.
- An all-zero state is unreachable from the default SEED. The block does not check for it.

Test Plan:
- NDW=1, SOF beat then 3 beats, in_data=0, in_prim=0 -> out_data = C2D2768D, 1F26B368, then k(2), k(3) matching the software model; out_sof only on the first beat.
- NDW=2, SOF beat in_data=0, in_prim=2'b00 -> out lane0=C2D2768D, lane1=1F26B368; with in_prim=2'b01 and lane0=7C95B5B5 -> lane0=7C95B5B5 unchanged, lane1=C2D2768D.
- NDW=4, beat of 4 primitives after SOF, then a data beat of zeros -> the primitive beat is unchanged and the data beat starts at C2D2768D.
- Backpressure: out_ready held low 5 cycles with in_valid high -> out_data stable; in_ready=0 after the first beat; no keystream skipped when released.
- lfsr_init mid-frame, then a non-SOF zero beat -> C2D2768D. rst asserted mid-frame -> out_valid=0 next cycle; the next data dword yields C2D2768D.
- scr_en=0 beats interleaved with data -> passed verbatim; the keystream resumes at the exact next index after re-enable.

Source files
------------

// File: rtl/sata_link_scrambler_mw.sv
`default_nettype none
// ============================================================================
// Module      : sata_link_scrambler_mw
// Description : SATA link-layer scrambler/descrambler, NDW dwords per beat.
//               Data dwords are XORed with the keystream of
//               G(X)=X^16+X^15+X^13+X^4+1. Primitives pass through and do not
//               consume keystream. The same block scrambles (TX) and
//               descrambles (RX).
// Ports       : clk, rst           clock, synchronous active-high reset
//               scr_en             1 = scramble data dwords, 0 = pass-through
//               lfsr_init          pulse, re-seeds the LFSR at the next edge
//               in_*  (valid/ready) input beat: data, per-lane prim, sof, eof
//               out_* (valid/ready) registered output beat, same fields
// Revision    : 1.0 - initial release
// ============================================================================
module sata_link_scrambler_mw #(
    parameter int          NDW  = 1,
    parameter logic [15:0] SEED = 16'hF0F6,
    parameter logic [15:0] POLY = 16'hA011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scr_en,
    input  logic              lfsr_init,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NDW-1:0] in_data,
    input  logic [NDW-1:0]    in_prim,
    input  logic              in_sof,
    input  logic              in_eof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NDW-1:0] out_data,
    output logic [NDW-1:0]    out_prim,
    output logic              out_sof,
    output logic              out_eof
);

    // Width of a count of data lanes, 0..NDW inclusive.
    localparam int CW = $clog2(NDW + 1);

    // The LFSR is a 16-bit shift register holding the last 16 stream bits,
    // bit 15 newest. Each shift produces feedback ^(state & POLY), which is
    // both the new bit 15 and the next keystream bit. Keystream bit i of a
    // dword is the i-th bit generated, which gives the SATA dword/byte order
    // directly (SEED 0xF0F6 -> first dword 0xC2D2768D).
    //
    // Response of one dword step to a single set state bit b:
    // {next_state[15:0], keystream[31:0]}.
    function automatic logic [47:0] lfsr_column(input int b);
        logic [15:0] st;
        logic [31:0] ks;
        logic        fb;
        st = 16'd1 << b;
        ks = '0;
        for (int i = 0; i < 32; i++) begin
            fb    = ^(st & POLY);
            ks[i] = fb;
            st    = {fb, st[15:1]};
        end
        return {st, ks};
    endfunction

    // The step is linear over GF(2), so the 16 columns form the whole
    // 16 -> 48 bit matrix. Built once at elaboration.
    function automatic logic [16*48-1:0] build_matrix();
        logic [16*48-1:0] m;
        m = '0;
        for (int b = 0; b < 16; b++) begin
            m[48*b +: 48] = lfsr_column(b);
        end
        return m;
    endfunction

    localparam logic [16*48-1:0] c_key_mat = build_matrix();

    // One matrix stage: XOR of the columns selected by the state bits.
    function automatic logic [47:0] key_stage(input logic [15:0] st);
        logic [47:0] acc;
        acc = '0;
        for (int b = 0; b < 16; b++) begin
            if (st[b]) begin
                acc = acc ^ c_key_mat[48*b +: 48];
            end
        end
        return acc;
    endfunction

    logic [15:0]       r_lfsr;
    logic              r_out_valid;
    logic [32*NDW-1:0] r_out_data;
    logic [NDW-1:0]    r_out_prim;
    logic              r_out_sof;
    logic              r_out_eof;

    logic              w_accept;
    logic [15:0]       w_state [NDW+1];
    logic [31:0]       w_key   [NDW];
    logic [CW-1:0]     w_cnt   [NDW];
    logic [CW-1:0]     w_cnt_total;
    logic [15:0]       w_adv_state;
    logic [15:0]       w_lfsr_next;
    logic [32*NDW-1:0] w_out_data;

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // SOF seeds the chain before lane 0, independent of scr_en.
    assign w_state[0] = in_sof ? SEED : r_lfsr;

    // Chain of NDW dword stages: w_key[m] is the keystream for the m-th data
    // dword of the beat, w_state[m+1] the state after it.
    for (genvar m = 0; m < NDW; m++) begin : g_stage
        logic [47:0] w_step;
        assign w_step       = key_stage(w_state[m]);
        assign w_key[m]     = w_step[31:0];
        assign w_state[m+1] = w_step[47:32];
    end

    // w_cnt[j] = number of data (non-primitive) lanes below lane j.
    always_comb begin : p_count
        logic [CW-1:0] v_acc;
        v_acc = '0;
        for (int i = 0; i < NDW; i++) begin
            w_cnt[i] = v_acc;
            v_acc    = v_acc + (in_prim[i] ? CW'(0) : CW'(1));
        end
        w_cnt_total = v_acc;
    end

    for (genvar j = 0; j < NDW; j++) begin : g_lane
        logic [31:0] w_lane_key;

        always_comb begin
            w_lane_key = '0;
            for (int m = 0; m < NDW; m++) begin
                if (w_cnt[j] == CW'(m)) begin
                    w_lane_key = w_key[m];
                end
            end
        end

        assign w_out_data[32*j +: 32] = (scr_en && !in_prim[j]) ?
                                        (in_data[32*j +: 32] ^ w_lane_key) :
                                        in_data[32*j +: 32];
    end

    // State after the beat: advanced by the number of data dwords consumed.
    always_comb begin
        w_adv_state = w_state[0];
        for (int m = 1; m <= NDW; m++) begin
            if (w_cnt_total == CW'(m)) begin
                w_adv_state = w_state[m];
            end
        end
    end

    // With scrambling off nothing is consumed, but an SOF still re-seeds.
    assign w_lfsr_next = scr_en ? w_adv_state : w_state[0];

    // lfsr_init wins over the beat's advance; the beat itself was already
    // processed from the pre-init state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else if (lfsr_init) begin
            r_lfsr <= SEED;
        end else if (w_accept) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_prim  <= '0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else if (in_ready) begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_data <= w_out_data;
                r_out_prim <= in_prim;
                r_out_sof  <= in_sof;
                r_out_eof  <= in_eof;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_prim  = r_out_prim;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;

endmodule
`default_nettype wire

// File: tb/tb_sata_link_scrambler_mw.sv
`default_nettype none
// ============================================================================
// Module      : tb_sata_link_scrambler_mw
// Description : Self-checking bench for sata_link_scrambler_mw (NDW=4).
//               Expected beats are computed by a serial reference LFSR when a
//               beat is accepted and compared when the DUT emits it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sata_link_scrambler_mw;

    localparam int          NDW  = 4;
    localparam logic [15:0] SEED = 16'hF0F6;
    localparam logic [31:0] K0   = 32'hC2D2768D;
    localparam logic [31:0] K1   = 32'h1F26B368;

    logic           clk;
    logic           rst;
    logic           scr_en;
    logic           lfsr_init;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic [3:0]     in_prim;
    logic           in_sof;
    logic           in_eof;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic [3:0]     out_prim;
    logic           out_sof;
    logic           out_eof;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sata_link_scrambler_mw #(
        .NDW  (NDW),
        .SEED (SEED),
        .POLY (16'hA011)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scr_en    (scr_en),
        .lfsr_init (lfsr_init),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_prim   (in_prim),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_prim  (out_prim),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   p;
        logic         s;
        logic         e;
    } beat_t;

    beat_t        sb[$];
    beat_t        mon_b;
    beat_t        prev_beat;
    logic         prev_stall;
    logic [15:0]  m_state;
    logic [127:0] last_out;
    int           n_total = 0;
    int           n_bad   = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial reference: taps X16+X15+X13+X4+1, newest bit at [15],
    // keystream bit i = i-th generated bit. Returns {next_state, key}.
    function automatic logic [47:0] ref_step(input logic [15:0] st_in);
        logic [15:0] st;
        logic [31:0] k;
        logic        fb;
        st = st_in;
        k  = '0;
        for (int i = 0; i < 32; i++) begin
            fb   = st[15] ^ st[13] ^ st[4] ^ st[0];
            k[i] = fb;
            st   = {fb, st[15:1]};
        end
        return {st, k};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_beat(input logic [127:0] d, input logic [3:0] p, input logic sof,
                              input logic eof, input logic en, input logic init);
        logic [15:0] st;
        logic [47:0] r;
        beat_t       b;
        st  = sof ? SEED : m_state;
        b.d = d;
        b.p = p;
        b.s = sof;
        b.e = eof;
        for (int j = 0; j < NDW; j++) begin
            if (en && !p[j]) begin
                r = ref_step(st);
                b.d[32*j +: 32] = d[32*j +: 32] ^ r[31:0];
                st = r[47:32];
            end
        end
        m_state = init ? SEED : st;
        sb.push_back(b);
    endtask

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input logic [127:0] d, input logic [3:0] p, input logic sof,
                        input logic eof, input logic en, input logic init);
        int waits;
        waits     = 0;
        in_data   = d;
        in_prim   = p;
        in_sof    = sof;
        in_eof    = eof;
        scr_en    = en;
        lfsr_init = init;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (in_ready) model_beat(d, p, sof, eof, en, init);
        else chk("accept_timeout", 160'(in_ready), 160'(1));
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        lfsr_init = 1'b0;
        in_sof    = 1'b0;
        in_eof    = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        #2;
        chk("drain_empty", 160'(sb.size()), 160'(0));
    endtask

    task automatic pulse_init();
        lfsr_init = 1'b1;
        @(posedge clk);
        #2;
        lfsr_init = 1'b0;
        m_state   = SEED;
    endtask

    // Output monitor: compare on each transfer, check stability under stall.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold", 160'({out_valid, out_data, out_prim, out_sof, out_eof}),
                    160'({1'b1, prev_beat}));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 160'(1), 160'(0));
                end else begin
                    mon_b = sb.pop_front();
                    chk("out_data", 160'(out_data), 160'(mon_b.d));
                    chk("out_flags", 160'({out_prim, out_sof, out_eof}),
                        160'({mon_b.p, mon_b.s, mon_b.e}));
                    last_out = out_data;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_data, out_prim, out_sof, out_eof};
        end
    end

    initial begin
        rst        = 1'b1;
        scr_en     = 1'b1;
        lfsr_init  = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_prim    = '0;
        in_sof     = 1'b0;
        in_eof     = 1'b0;
        out_ready  = 1'b1;
        m_state    = SEED;
        prev_stall = 1'b0;
        last_out   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_out_regs", 160'({out_data, out_prim, out_sof, out_eof}), 160'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 160'(in_ready), 160'(1));
        @(posedge clk);
        #2;

        // SOF zero beat: lanes carry k(0)..k(3).
        send(128'h0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        chk("k0_abs", 160'(last_out[31:0]), 160'(K0));
        chk("k1_abs", 160'(last_out[63:32]), 160'(K1));
        send(rnd128(), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        send(rnd128(), 4'b0101, 1'b0, 1'b1, 1'b1, 1'b0);

        // All-primitive SOF beat, then a zero data beat starting at k(0).
        send({4{32'h7C95B5B5}}, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
        send(128'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("prim_then_k0", 160'(last_out[31:0]), 160'(K0));

        // Lane 0 primitive: lane 1 takes k(0), lane 2 takes k(1).
        send({96'h0, 32'h7C95B5B5}, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        chk("lane0_prim", 160'(last_out[31:0]), 160'(32'h7C95B5B5));
        chk("lane1_k0", 160'(last_out[63:32]), 160'(K0));
        chk("lane2_k1", 160'(last_out[95:64]), 160'(K1));

        // scr_en=0 interleaved; SOF with scr_en=0 still re-seeds.
        send(rnd128(), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        send(rnd128(), 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0);
        send(rnd128(), 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        send(rnd128(), 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
        send(rnd128(), 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        send(128'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("sof_en0_reseed", 160'(last_out[31:0]), 160'(K0));

        // Backpressure: output held, in_ready low, no keystream skipped.
        out_ready = 1'b0;
        fork
            begin
                send(rnd128(), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
                send(rnd128(), 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
                send(128'h0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
            end
            begin
                @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready", 160'(in_ready), 160'(0));
                repeat (4) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // lfsr_init mid-frame, then a non-SOF zero beat.
        send(rnd128(), 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        send(rnd128(), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_init();
        send(128'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("init_k0", 160'(last_out[31:0]), 160'(K0));

        // lfsr_init together with a beat: beat uses the old state.
        send(rnd128(), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
        send(128'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("init_same_cycle", 160'(last_out[31:0]), 160'(K0));

        // Reset mid-frame with a beat stuck in the output stage.
        send(rnd128(), 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        out_ready = 1'b0;
        send(rnd128(), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        m_state = SEED;
        @(negedge clk);
        chk("rst_drop_valid", 160'(out_valid), 160'(0));
        @(posedge clk);
        #2 out_ready = 1'b1;
        send(128'h0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("rst_k0", 160'(last_out[31:0]), 160'(K0));

        // Random mix of lanes, frames and enables.
        for (int i = 0; i < 40; i++) begin
            send(rnd128(), 4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0), 1'b0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
